// File: rtl/multicycle_wb_arbiter.sv
// Round-robin arbiter merging multicycle unit results onto writeback group 1.
// Define MC_WB_OUTPUT_REG_EN to register wb_valid/wb_id/wb_data (1-cycle latency).
module multicycle_wb_arbiter #(
  parameter int NUM_UNITS = 3,
  parameter int ID_W      = 3,
  parameter int DATA_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_UNITS-1:0]              unit_valid,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]    unit_id,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]  unit_data,
  output logic [NUM_UNITS-1:0]              unit_ack,
  input  logic                              wb_hold,
  output logic                              wb_valid,
  output logic [ID_W-1:0]                   wb_id,
  output logic [DATA_W-1:0]                 wb_data
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  grant_idx, cand;
  logic              grant_found, gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [DATA_W-1:0] gnt_data;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_UNITS);
      if (unit_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign gnt_vld  = grant_found & ~wb_hold & ~rst;
  assign gnt_id   = unit_id[grant_idx];
  assign gnt_data = unit_data[grant_idx];

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_ack
    assign unit_ack[i] = gnt_vld && (grant_idx == PTR_W'(i));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld)
      rr_ptr_d = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

`ifdef MC_WB_OUTPUT_REG_EN
  logic              wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]   wb_id_q, wb_id_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  always_comb begin
    wb_valid_d = gnt_vld;
    wb_id_d    = gnt_id;
    wb_data_d  = gnt_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_data  = wb_data_q;
`else
  assign wb_valid = gnt_vld;
  assign wb_id    = gnt_id;
  assign wb_data  = gnt_data;
`endif

endmodule

// File: tb/tb_multicycle_wb_arbiter.sv
// Scoreboard bench for multicycle_wb_arbiter (NUM_UNITS=3); works with either output latency.
module tb_multicycle_wb_arbiter;
  localparam int N = 3;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] data;
  } pkt_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wb_hold = 1'b0;
  logic [N-1:0]        unit_valid = '0;
  logic [N-1:0][2:0]   unit_id;
  logic [N-1:0][31:0]  unit_data;
  logic [N-1:0]        unit_ack;
  logic                wb_valid;
  logic [2:0]          wb_id;
  logic [31:0]         wb_data;

  logic [2:0]  id_tab   [N] = '{3'd1, 3'd3, 3'd5};
  logic [31:0] data_tab [N] = '{32'h1111_0000, 32'h2222_0001, 32'hDEADBEEF};

  pkt_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   mptr = 0;

  multicycle_wb_arbiter #(.NUM_UNITS(N), .ID_W(3), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .unit_valid (unit_valid),
    .unit_id    (unit_id),
    .unit_data  (unit_data),
    .unit_ack   (unit_ack),
    .wb_hold    (wb_hold),
    .wb_valid   (wb_valid),
    .wb_id      (wb_id),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic void push_pkt(input int g);
    pkt_t p;
    p.id   = id_tab[g];
    p.data = data_tab[g];
    exp_q.push_back(p);
  endfunction

  // Writeback monitor: every wb packet must match the oldest expected grant.
  always begin
    @(negedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got id=%0d data=%h, required no packet", wb_id, wb_data);
      end else begin
        pkt_t p;
        p = exp_q.pop_front();
        if (wb_id !== p.id || wb_data !== p.data) begin
          failures++;
          $display("FAIL wb_packet: got id=%0d data=%h, required id=%0d data=%h",
                   wb_id, wb_data, p.id, p.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; unit_valid = 3'b111; wb_hold = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (unit_ack !== 3'b000) begin
        failures++; $display("FAIL reset_ack: got %b, required 000", unit_ack);
      end
      checks++;
      if (wb_valid !== 1'b0) begin
        failures++; $display("FAIL reset_wb_valid: got %b, required 0", wb_valid);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; unit_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++; $display("FAIL reset_rr_ptr: got %0d, required 0", dut.rr_ptr_q);
    end
    mptr = 0;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      unit_valid = 3'b111; wb_hold = 1'b0;
      @(negedge clk);
      checks++;
      if (unit_ack !== 3'(1 << (c % 3))) begin
        failures++; $display("FAIL rr_order c=%0d: got %b, required %b", c, unit_ack, 3'(1 << (c % 3)));
      end
      checks++;
      if (dut.rr_ptr_q !== 2'(c % 3)) begin
        failures++; $display("FAIL rr_ptr c=%0d: got %0d, required %0d", c, dut.rr_ptr_q, c % 3);
      end
      push_pkt(c % 3);
    end
    mptr = 0;
  endtask

  task automatic test_single_unit();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      unit_valid = 3'b100;
      @(negedge clk);
      checks++;
      if (unit_ack !== 3'b100) begin
        failures++; $display("FAIL single_ack c=%0d: got %b, required 100", c, unit_ack);
      end
      push_pkt(2);
    end
    mptr = 0;
  endtask

  task automatic test_hold();
    // Move the pointer to 1 first so release must honour it.
    @(posedge clk); #1;
    unit_valid = 3'b001;
    @(negedge clk);
    checks++;
    if (unit_ack !== 3'b001) begin
      failures++; $display("FAIL hold_pre_ack: got %b, required 001", unit_ack);
    end
    push_pkt(0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      unit_valid = 3'b011; wb_hold = 1'b1;
      @(negedge clk);
      checks++;
      if (unit_ack !== 3'b000) begin
        failures++; $display("FAIL hold_ack c=%0d: got %b, required 000", c, unit_ack);
      end
      checks++;
      if (dut.rr_ptr_q !== 2'd1) begin
        failures++; $display("FAIL hold_rr_ptr c=%0d: got %0d, required 1", c, dut.rr_ptr_q);
      end
      if (c >= 1) begin
        checks++;
        if (wb_valid !== 1'b0) begin
          failures++; $display("FAIL hold_wb_valid c=%0d: got %b, required 0", c, wb_valid);
        end
      end
    end
    @(posedge clk); #1;
    wb_hold = 1'b0;
    @(negedge clk);
    checks++;
    if (unit_ack !== 3'b010) begin
      failures++; $display("FAIL hold_release_ack: got %b, required 010", unit_ack);
    end
    push_pkt(1);
    mptr = 2;
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    unit_valid = 3'b101;
    @(negedge clk);
    checks++;
    if (dut.rr_ptr_q !== 2'd2) begin
      failures++; $display("FAIL wrap_ptr_start: got %0d, required 2", dut.rr_ptr_q);
    end
    checks++;
    if (unit_ack !== 3'b100) begin
      failures++; $display("FAIL wrap_ack0: got %b, required 100", unit_ack);
    end
    push_pkt(2);
    @(posedge clk); #1;
    unit_valid = 3'b001;
    @(negedge clk);
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++; $display("FAIL wrap_ptr: got %0d, required 0", dut.rr_ptr_q);
    end
    checks++;
    if (unit_ack !== 3'b001) begin
      failures++; $display("FAIL wrap_ack1: got %b, required 001", unit_ack);
    end
    push_pkt(0);
    mptr = 1;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    unit_valid = 3'b010;
    @(negedge clk);
    checks++;
    if (unit_ack !== 3'b010) begin
      failures++; $display("FAIL rstmid_pre_ack: got %b, required 010", unit_ack);
    end
    push_pkt(1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.rr_ptr_q !== 2'd2) begin
      failures++; $display("FAIL rstmid_ptr_before: got %0d, required 2", dut.rr_ptr_q);
    end
    checks++;
    if (unit_ack !== 3'b000) begin
      failures++; $display("FAIL rstmid_ack: got %b, required 000", unit_ack);
    end
    @(posedge clk); #1;
    rst = 1'b0; unit_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_wb_valid: got %b, required 0", wb_valid);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++; $display("FAIL rstmid_ptr: got %0d, required 0", dut.rr_ptr_q);
    end
    mptr = 0;
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    unit_valid = 3'b011;
    @(negedge clk);
    checks++;
    if (unit_ack !== 3'b001) begin
      failures++; $display("FAIL flush_ack0: got %b, required 001", unit_ack);
    end
    push_pkt(0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      unit_valid = 3'b000;
      @(negedge clk);
      checks++;
      if (unit_ack !== 3'b000) begin
        failures++; $display("FAIL flush_ack c=%0d: got %b, required 000", c, unit_ack);
      end
      checks++;
      if (dut.rr_ptr_q !== 2'd1) begin
        failures++; $display("FAIL flush_ptr c=%0d: got %0d, required 1", c, dut.rr_ptr_q);
      end
    end
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++; $display("FAIL flush_wb_valid: got %b, required 0", wb_valid);
    end
    mptr = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      int g;
      logic [N-1:0] exp_ack;
      @(posedge clk); #1;
      unit_valid = 3'($urandom_range(0, 7));
      wb_hold    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      g = model_grant(unit_valid, mptr);
      exp_ack = (g >= 0 && !wb_hold) ? 3'(1 << g) : 3'b000;
      checks++;
      if (unit_ack !== exp_ack) begin
        failures++; $display("FAIL rand_ack c=%0d: got %b, required %b", c, unit_ack, exp_ack);
      end
      checks++;
      if (dut.rr_ptr_q !== 2'(mptr)) begin
        failures++; $display("FAIL rand_ptr c=%0d: got %0d, required %0d", c, dut.rr_ptr_q, mptr);
      end
      if (g >= 0 && !wb_hold) begin
        push_pkt(g);
        mptr = (g + 1) % N;
      end
    end
    @(posedge clk); #1;
    unit_valid = 3'b000; wb_hold = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      unit_id[i]   = id_tab[i];
      unit_data[i] = data_tab[i];
    end
    test_reset();
    test_round_robin();
    test_single_unit();
    test_hold();
    test_wrap();
    test_reset_mid();
    test_flush();
    test_random();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d pending packets, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_wb_arbiter.md
MULTICYCLE_WB_ARBITER -- requirements
Module: multicycle_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 3, number of multicycle execution units sharing writeback group 1 (legal range 1..8).
REQ-002 SHALL have parameter ID_W, default 3, instruction ID width (matches LOG2_MAX_IDS).
REQ-003 SHALL have parameter DATA_W, default 32, result data width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port unit_valid  input  NUM_UNITS  per-unit result ready.
REQ-007 SHALL have port unit_id  input  NUM_UNITS x ID_W  per-unit instruction ID.
REQ-008 SHALL have port unit_data  input  NUM_UNITS x DATA_W  per-unit result.
REQ-009 SHALL have port unit_ack  output  NUM_UNITS  one-hot grant; unit's result is consumed this cycle.
REQ-010 SHALL have port wb_hold  input  1  suppress all grants this cycle.
REQ-011 SHALL have port wb_valid  output  1  writeback group 1 packet valid.
REQ-012 SHALL have port wb_id  output  ID_W  ID of written-back instruction.
REQ-013 SHALL have port wb_data  output  DATA_W  written-back result.

Function
REQ-014 SHALL keep a round-robin pointer rr_ptr of width max(1,clog2(NUM_UNITS)), range 0..NUM_UNITS-1.
REQ-015 SHALL grant the first unit g with unit_valid[g]=1 scanning rr_ptr, rr_ptr+1, ... modulo NUM_UNITS.
REQ-016 SHALL assert unit_ack[g] combinationally in the grant cycle; at most one unit_ack bit high per cycle.
REQ-017 SHALL assert no unit_ack when wb_hold=1 or no unit_valid bit is set.
REQ-018 SHALL on a grant set rr_ptr to g+1, wrapping NUM_UNITS-1 -> 0; rr_ptr otherwise unchanged.
REQ-019 SHALL require units to hold valid/id/data stable until acked; an unacked unit SHALL NOT be dropped.
REQ-020 SHALL accept back-to-back grants, one per cycle, with no idle cycle between them, including consecutive grants to the same unit when it is the only requester.
REQ-021 SHALL guarantee each continuously valid unit is granted within NUM_UNITS cycles in which wb_hold=0.
REQ-022 SHALL drive wb_id/wb_data from the granted unit; wb_valid high only for a cycle (or the cycle after, see Configuration) with a grant.
REQ-023 SHALL tolerate unit_valid deasserting without an ack (unit flushed); no state change results.
REQ-024 SHALL with NUM_UNITS=1 degenerate to ack = unit_valid[0] & ~wb_hold, rr_ptr fixed at 0.

Reset
REQ-025 SHALL on rst=1 at a clock edge set rr_ptr=0 and, when registered, wb_valid=0, wb_id=0, wb_data=0.
REQ-026 SHALL force unit_ack=0 while rst=1, regardless of unit_valid.
REQ-027 SHALL discard any grant pending in the reset cycle; no wb_valid in the following cycle.

Configuration
REQ-028 SHALL compile registered output when MC_WB_OUTPUT_REG_EN is defined: wb_valid/wb_id/wb_data are flops loaded from the grant, so wb_valid appears 1 cycle after unit_ack.
REQ-029 SHALL without MC_WB_OUTPUT_REG_EN drive wb_valid/wb_id/wb_data combinationally from the grant, in the same cycle as unit_ack (0 latency); outputs then have no reset value of their own.

Verification
REQ-030 SHALL test, NUM_UNITS=3, rst then all three valid continuously, wb_hold=0 -> ack order 0,1,2,0,1,2 on consecutive cycles, rr_ptr 1,2,0,1,...
REQ-031 SHALL test only unit 2 valid with id=5 data=0xDEADBEEF -> unit_ack=3'b100 each cycle; wb_id=5, wb_data=0xDEADBEEF (next cycle if MC_WB_OUTPUT_REG_EN).
REQ-032 SHALL test units 0,1 valid with wb_hold=1 for 3 cycles -> no ack, wb_valid=0, rr_ptr unchanged; on release unit rr_ptr points to is acked first.
REQ-033 SHALL test rr_ptr=2 with units 0 and 2 valid -> unit 2 acked, rr_ptr wraps to 0, unit 0 acked next cycle.
REQ-034 SHALL test rst asserted in a cycle with unit 1 valid and rr_ptr=2 -> unit_ack=0, next cycle wb_valid=0, rr_ptr=0.
REQ-035 SHALL test unit 1 dropping valid unacked while unit 0 granted -> no ack to unit 1, no wb packet with unit 1's ID.
